reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Central reset controller for the design.
- Collects synchronous reset requests from several sources (synchronized pad reset, UART break detector, soft-reset register) and applies a minimum hold.
- Then releases NUM_DOM reset domains one at a time, in index order, with a ready handshake per domain.
- Sits downstream of the per-source reset synchronizers and drives the reset inputs of all functional blocks.

Parameters:
- NUM_REQ, 3: number of reset request inputs.
- NUM_DOM, 3: number of reset domains released in sequence.
- HOLD_CYCLES, 16: minimum cycles all domains stay in reset after the last request drops.
- GAP_CYCLES, 4: cycles between releasing domain k and sampling its ready.
- CNT_W, 5: counter width; must hold max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset. Assertion is async; deassertion is already synchronous to clk.
- req_i  input  NUM_REQ  active-high reset requests, already synchronous to clk.
- req_mask_i  input  NUM_REQ  1 = request bit ignored.
- dom_rst_o  output  NUM_DOM  active-high reset per domain.
- dom_ready_i  input  NUM_DOM  domain k reports initialisation complete.
- cause_o  output  NUM_REQ  sticky record of which requests caused the last reset.
- cause_clr_i  input  1  one-cycle pulse; clears cause_o.
- busy_o  output  1  high whenever the state is not RUN.

Behaviour:
- Effective request: any_req = |(req_i & ~req_mask_i).
- Reset values (rst_n low):
  - state = HOLD, cnt = 0, dom_idx = 0.
  - dom_rst_o = all 1s, busy_o = 1.
  - cause_o = 0, timeout_o = 0.
- State HOLD:
  - All dom_rst_o = 1.
  - Any cycle with any_req = 1 forces cnt = 0.
  - Otherwise cnt increments.
  - When cnt == HOLD_CYCLES-1 with any_req = 0: go to GAP, dom_idx = 0, cnt = 0, and clear dom_rst_o[0] on the same edge.
- State GAP:
  - cnt increments.
  - At cnt == GAP_CYCLES-1, go to WAIT.
- State WAIT:
  - Waits for dom_ready_i[dom_idx] = 1.
  - If dom_idx == NUM_DOM-1, go to RUN.
  - Else increment dom_idx, clear dom_rst_o[dom_idx+1] on the same edge, cnt = 0, go to GAP.
- State RUN:
  - All dom_rst_o = 0, busy_o = 0.
- Latency:
  - Last request drop to dom_rst_o[0] low: HOLD_CYCLES cycles.
  - Each release edge to the next: at least GAP_CYCLES+1 cycles.
- Request from any state (any_req = 1):
  - Next edge: state = HOLD, cnt = 0, dom_idx = 0, all dom_rst_o = 1. This includes a request mid-sequence.
  - cause_o |= req_i & ~req_mask_i, every cycle.
- dom_ready_i rules:
  - Ignored for domains not currently selected by WAIT.
  - A domain dropping ready after release has no effect.
- cause_clr_i: clears cause_o. If it coincides with a new request, the new request bits win (set after clear).
- Once released, a domain's dom_rst_o stays low until the next request or rst_n. Release order is strictly 0..NUM_DOM-1.
- Masked requests have no effect and are not recorded.
- rst_n low mid-sequence: immediately returns to the reset values; cause_o is lost.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: RSTSEQ_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 24) and output timeout_o (1 bit, sticky).
  - In WAIT, cnt increments each cycle.
  - If cnt reaches TIMEOUT_CYCLES-1 without ready: set timeout_o and advance exactly as if ready had arrived.
  - timeout_o is cleared by cause_clr_i or rst_n.
- Undefined: WAIT holds indefinitely, and the timeout_o port is absent.

Test Plan:
- Power-up: hold rst_n low 5 cycles, release, all dom_ready_i = 1, req_i = 0.
  - dom_rst_o[0] falls 16 cycles after release; [1] and [2] follow at 5-cycle spacing; busy_o = 0 after the sequence; cause_o = 000.
- Hold extension: pulse req_i = 001 at cycle 10 of HOLD.
  - HOLD restarts; dom_rst_o[0] falls 16 cycles after the pulse ends; cause_o = 001.
- Mid-sequence request: req_i = 010 asserted while in GAP for domain 1.
  - All dom_rst_o = 111 on the next edge; sequence restarts from domain 0; cause_o = 010.
- Handshake stall: dom_ready_i[1] held 0 for 40 cycles.
  - dom_rst_o[2] stays 1 until 1 cycle after ready rises; busy_o stays 1 throughout.
- Mask and clear:
  - req_mask_i = 100 with req_i = 100: no reset, and cause_o stays 0.
  - cause_clr_i and req_i = 001 in the same cycle: cause_o = 001.
- With RSTSEQ_TIMEOUT_EN and dom_ready_i[0] stuck at 0:
  - timeout_o rises 24 cycles into WAIT; domain 1 release follows on that edge.

Source files
------------

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Central reset controller. Merges synchronous reset requests,
//            holds every domain in reset for a minimum number of cycles after
//            the last request drops, then releases the domains one at a time
//            in index order, waiting for each domain's ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   rst_n        in   async-assert / sync-deassert active-low reset
//   req_i        in   [NUM_REQ] active-high reset requests (clk-synchronous)
//   req_mask_i   in   [NUM_REQ] 1 = matching request bit ignored
//   dom_rst_o    out  [NUM_DOM] active-high reset per domain
//   dom_ready_i  in   [NUM_DOM] domain k finished initialisation
//   cause_o      out  [NUM_REQ] sticky record of requests that caused reset
//   cause_clr_i  in   one-cycle pulse clearing cause_o (and timeout_o)
//   timeout_o    out  sticky ready-timeout flag (RSTSEQ_TIMEOUT_EN only)
//   busy_o       out  high whenever the sequencer is not in RUN
// Build option
//   RSTSEQ_TIMEOUT_EN : when defined, a domain that never reports ready is
//                       released anyway after TIMEOUT_CYCLES in WAIT.
// ============================================================================
module reset_sequencer #(
  parameter int NUM_REQ        = 3,
  parameter int NUM_DOM        = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
`ifdef RSTSEQ_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 24,
`endif
  parameter int CNT_W          = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] req_mask_i,
  output logic [NUM_DOM-1:0] dom_rst_o,
  input  logic [NUM_DOM-1:0] dom_ready_i,
  output logic [NUM_REQ-1:0] cause_o,
  input  logic               cause_clr_i,
`ifdef RSTSEQ_TIMEOUT_EN
  output logic               timeout_o,
`endif
  output logic               busy_o
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_GAP  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   dom_idx_q, dom_idx_d;
  logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
  logic [NUM_REQ-1:0] cause_q, cause_d;
  logic               busy_q, busy_d;
`ifdef RSTSEQ_TIMEOUT_EN
  logic               timeout_q, timeout_d;
`endif

  logic [NUM_REQ-1:0] req_eff;
  logic               any_req;
  logic [IDX_W-1:0]   idx_nxt;
  logic               advance;

  always_comb begin
    req_eff   = req_i & ~req_mask_i;
    any_req   = |req_eff;
    idx_nxt   = dom_idx_q + IDX_W'(1);
    advance   = 1'b0;

    state_d   = state_q;
    cnt_d     = cnt_q;
    dom_idx_d = dom_idx_q;
    dom_rst_d = dom_rst_q;

    // Clear first, then OR in new requests: a request that coincides with
    // the clear pulse is still recorded.
    cause_d   = (cause_clr_i ? '0 : cause_q) | req_eff;
`ifdef RSTSEQ_TIMEOUT_EN
    timeout_d = cause_clr_i ? 1'b0 : timeout_q;
`endif

    if (any_req) begin
      // A request from any state restarts the whole sequence.
      state_d   = ST_HOLD;
      cnt_d     = '0;
      dom_idx_d = '0;
      dom_rst_d = '1;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          dom_rst_d = '1;
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d      = ST_GAP;
            cnt_d        = '0;
            dom_idx_d    = '0;
            dom_rst_d[0] = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_GAP: begin
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            state_d = ST_WAIT;
            cnt_d   = '0;   // WAIT reuses the counter for its timeout
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_WAIT: begin
`ifdef RSTSEQ_TIMEOUT_EN
          if (dom_ready_i[dom_idx_q]) begin
            advance = 1'b1;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            advance   = 1'b1;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          advance = dom_ready_i[dom_idx_q];
`endif
          if (advance) begin
            cnt_d = '0;
            if (dom_idx_q == IDX_W'(NUM_DOM - 1)) begin
              state_d   = ST_RUN;
              dom_rst_d = '0;
            end else begin
              state_d            = ST_GAP;
              dom_idx_d          = idx_nxt;
              dom_rst_d[idx_nxt] = 1'b0;
            end
          end
        end

        ST_RUN: begin
          dom_rst_d = '0;
        end

        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end

    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      dom_idx_q <= '0;
      dom_rst_q <= '1;
      cause_q   <= '0;
      busy_q    <= 1'b1;
`ifdef RSTSEQ_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dom_idx_q <= dom_idx_d;
      dom_rst_q <= dom_rst_d;
      cause_q   <= cause_d;
      busy_q    <= busy_d;
`ifdef RSTSEQ_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign dom_rst_o = dom_rst_q;
  assign cause_o   = cause_q;
  assign busy_o    = busy_q;
`ifdef RSTSEQ_TIMEOUT_EN
  assign timeout_o = timeout_q;
`endif

endmodule
`default_nettype wire
